cmp_result_filter: RTL and testbench
====================================

Name: cmp_result_filter

Overview:
- Downstream stage of the 4-bit magnitude comparator. Consumes its 3-bit one-hot result {G,E,L} and qualifies each sample with a valid strobe.
- Publishes a debounced, registered result: a new result is accepted only after STABLE_CNT consecutive identical valid samples.
- Also provides a change pulse, a change counter and a sticky illegal-code flag.
- Sits between the combinational comparator and control/display logic, which must not react to single-sample glitches.

Parameters:
STABLE_CNT, 4, number of consecutive identical legal valid samples required to accept a result; legal range 1..255.
CNT_W, 8, width of the change counter (and of the histogram counters when enabled).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  r_in is sampled this cycle when high
r_in  input  3  comparator result; [2]=G (A>B), [1]=E (A==B), [0]=L (A<B)
clr  input  1  synchronous clear of change_cnt and err (and histograms)
filt_o  output  3  debounced result, same bit order as r_in; 000 = no result yet
chg_o  output  1  one-cycle pulse when filt_o changes
change_cnt  output  CNT_W  number of filt_o updates since reset/clr, wraps modulo 2^CNT_W
err  output  1  sticky; set when a valid sample is not one-hot
state_o  output  2  FSM state: 00 EMPTY, 01 SETTLING, 10 LOCKED

Behaviour:
- Reset (rst=1 at clock edge, overrides everything):
  - filt_o=000, chg_o=0, change_cnt=0, err=0, state_o=EMPTY.
  - Internal candidate cand=000, run counter run=0.
- Legal codes are 100, 010 and 001 only.
- in_valid=0: all registers hold; chg_o=0.
- in_valid=1 with legal r_in:
  - If r_in==cand: run increments, saturating at STABLE_CNT.
  - Otherwise: cand<=r_in and run<=1.
  - Acceptance: if the post-update run equals STABLE_CNT and cand differs from filt_o, then on the same edge filt_o<=cand, chg_o<=1 for exactly one cycle, and change_cnt increments.
  - Latency: filt_o is visible the cycle after the edge that registers the STABLE_CNT-th matching sample.
  - STABLE_CNT=1 means a single sample is accepted.
- in_valid=1 with illegal r_in (000, 011, 101, 110, 111):
  - err<=1; cand<=000, run<=0; filt_o holds; no chg_o.
- A re-accepted value equal to filt_o produces no pulse and no count.
- clr=1:
  - change_cnt<=0 and err<=0, taking priority over a same-cycle increment or error set.
  - filt_o and the FSM are unaffected, and chg_o still pulses normally.
- change_cnt wraps from 2^CNT_W-1 to 0; no saturation.
- FSM transitions are evaluated from next-state values:
  - EMPTY: filt_o==000 and no candidate pending. Goes to SETTLING on a legal sample unless acceptance occurs on that same edge (STABLE_CNT=1), in which case it goes straight to LOCKED.
  - SETTLING: cand!=filt_o and 0<run<STABLE_CNT. Goes to LOCKED on acceptance. Goes to LOCKED if the sample equals filt_o and filt_o!=000 (glitch abandoned). An illegal sample returns it to LOCKED if filt_o!=000, else to EMPTY.
  - LOCKED: filt_o!=000 and cand==filt_o (or cand==000 after an illegal sample). Goes to SETTLING on a legal sample differing from filt_o.
- Reset mid-settling discards the candidate and returns all outputs to reset values on the next cycle.

Optional Feature:
- Macro CMP_HIST_EN.
- When defined: adds output ports gt_cnt, eq_cnt and lt_cnt (each CNT_W wide).
  - Each counts legal valid raw samples of its code, before filtering, saturating at 2^CNT_W-1.
  - Each is cleared by rst or clr.
- When not defined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and r_in=100 -> filt_o=000, chg_o=0, change_cnt=0, err=0, state_o=00 throughout.
- Acceptance: STABLE_CNT=4, r_in=100 valid for 5 cycles -> filt_o=100 and chg_o=1 the cycle after the 4th sample, change_cnt=1, state_o=10. The 5th sample gives no pulse.
- Glitch rejection: from filt_o=100, feed 010 x3, 100 x1, 010 x3 -> filt_o stays 100. One more 010 -> filt_o=010, chg_o pulse, change_cnt=2.
- Valid gaps: r_in=001 with in_valid pattern 1,0,1,0,1,0,1 -> filt_o=001 only after the 7th cycle (4th valid), with exactly one chg_o pulse.
- Illegal and clear: a valid r_in=011 -> err=1, run reset, filt_o unchanged. Then assert clr on the same edge as an acceptance -> change_cnt=0, err=0, chg_o=1, filt_o updated.
- Wrap and reset mid-settle: CNT_W=2 with 4 accepted changes -> change_cnt=0. Then 2 samples of 010 followed by rst -> all outputs at reset values, and a subsequent 010 x3 does not update filt_o.

Source files
------------

// File: rtl/cmp_result_filter.sv
// Debounce filter for the one-hot {G,E,L} result of the 4-bit magnitude comparator.
// Define CMP_HIST_EN to add per-code raw sample histogram counters.
module cmp_result_filter #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       r_in,
  input  logic             clr,
  output logic [2:0]       filt_o,
  output logic             chg_o,
  output logic [CNT_W-1:0] change_cnt,
  output logic             err,
  output logic [1:0]       state_o
`ifdef CMP_HIST_EN
  ,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
`endif
);

  localparam int unsigned RUN_W = 8;

  typedef enum logic [1:0] {
    S_EMPTY    = 2'b00,
    S_SETTLING = 2'b01,
    S_LOCKED   = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cand;
  logic [RUN_W-1:0] r_run;
  logic [2:0]       r_filt;
  logic             r_chg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic             w_legal;
  logic             w_accept;
  logic [2:0]       w_cand_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic [2:0]       w_filt_nxt;

  assign w_legal = (r_in == 3'b100) || (r_in == 3'b010) || (r_in == 3'b001);

  // Candidate/run tracking and acceptance decision for this edge
  always_comb begin
    w_cand_nxt = r_cand;
    w_run_nxt  = r_run;
    w_accept   = 1'b0;
    w_filt_nxt = r_filt;
    if (in_valid) begin
      if (w_legal) begin
        if (r_in == r_cand) begin
          w_run_nxt = (r_run == RUN_W'(STABLE_CNT)) ? r_run : r_run + RUN_W'(1);
        end else begin
          w_cand_nxt = r_in;
          w_run_nxt  = RUN_W'(1);
        end
        if ((w_run_nxt == RUN_W'(STABLE_CNT)) && (w_cand_nxt != r_filt)) begin
          w_accept   = 1'b1;
          w_filt_nxt = w_cand_nxt;
        end
      end else begin
        w_cand_nxt = 3'b000;
        w_run_nxt  = '0;
      end
    end
  end

  // Next state, judged from the post-update candidate and filter values
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (in_valid && w_legal) w_state_nxt = w_accept ? S_LOCKED : S_SETTLING;
      end
      S_SETTLING: begin
        if (w_accept) begin
          w_state_nxt = S_LOCKED;
        end else if (in_valid && !w_legal) begin
          w_state_nxt = (r_filt != 3'b000) ? S_LOCKED : S_EMPTY;
        end else if (in_valid && (w_cand_nxt == r_filt) && (r_filt != 3'b000)) begin
          w_state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (in_valid && w_legal && (w_cand_nxt != r_filt))
          w_state_nxt = w_accept ? S_LOCKED : S_SETTLING;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_cand  <= 3'b000;
      r_run   <= '0;
      r_filt  <= 3'b000;
      r_chg   <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_run   <= w_run_nxt;
      r_filt  <= w_filt_nxt;
      r_chg   <= w_accept;
      // clr wins over a same-edge count or error
      if (clr) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
        if (in_valid && !w_legal) r_err <= 1'b1;
      end
    end
  end

  assign filt_o     = r_filt;
  assign chg_o      = r_chg;
  assign change_cnt = r_cnt;
  assign err        = r_err;
  assign state_o    = r_state;

`ifdef CMP_HIST_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_gt;
  logic [CNT_W-1:0] r_eq;
  logic [CNT_W-1:0] r_lt;
  logic             w_smp;

  assign w_smp = in_valid && w_legal;

  // Raw per-code sample counts, saturating
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_gt <= '0;
      r_eq <= '0;
      r_lt <= '0;
    end else if (w_smp) begin
      if (r_in[2] && (r_gt != CNT_MAX)) r_gt <= r_gt + CNT_W'(1);
      if (r_in[1] && (r_eq != CNT_MAX)) r_eq <= r_eq + CNT_W'(1);
      if (r_in[0] && (r_lt != CNT_MAX)) r_lt <= r_lt + CNT_W'(1);
    end
  end

  assign gt_cnt = r_gt;
  assign eq_cnt = r_eq;
  assign lt_cnt = r_lt;
`endif

endmodule

// File: tb/tb_cmp_result_filter.sv
// Self-checking bench for cmp_result_filter: queue-based reference model plus directed literal checks.
module tb_cmp_result_filter;

  localparam int unsigned STABLE = 4;
  localparam int unsigned CW     = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [2:0]    r_in;
  logic          clr;
  logic [2:0]    filt_o;
  logic          chg_o;
  logic [CW-1:0] change_cnt;
  logic          err;
  logic [1:0]    state_o;
`ifdef CMP_HIST_EN
  logic [CW-1:0] gt_cnt, eq_cnt, lt_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cmp_result_filter #(.STABLE_CNT(STABLE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .r_in(r_in), .clr(clr),
    .filt_o(filt_o), .chg_o(chg_o), .change_cnt(change_cnt), .err(err),
    .state_o(state_o)
`ifdef CMP_HIST_EN
    , .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the window of recent legal samples since the last illegal one
  logic [2:0] q[$];
  logic [2:0] m_filt;
  logic       m_chg;
  int         m_cnt;
  logic       m_err;
  int         m_state;
  int         m_gt, m_eq, m_lt;
  localparam int CMOD = 1 << CW;

  function automatic bit window_full_same();
    if (q.size() != STABLE) return 1'b0;
    foreach (q[i]) if (q[i] != q[0]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_filt = 3'b000; m_chg = 1'b0; m_cnt = 0; m_err = 1'b0; m_state = 0;
      m_gt = 0; m_eq = 0; m_lt = 0;
    end else begin
      m_chg = 1'b0;
      if (in_valid) begin
        if (r_in == 3'b100 || r_in == 3'b010 || r_in == 3'b001) begin
          q.push_back(r_in);
          if (q.size() > STABLE) void'(q.pop_front());
          if (r_in == 3'b100 && m_gt < CMOD - 1) m_gt++;
          if (r_in == 3'b010 && m_eq < CMOD - 1) m_eq++;
          if (r_in == 3'b001 && m_lt < CMOD - 1) m_lt++;
          if (window_full_same() && q[0] != m_filt) begin
            m_filt = q[0];
            m_chg  = 1'b1;
            m_cnt  = (m_cnt + 1) % CMOD;
          end
        end else begin
          m_err = 1'b1;
          q.delete();
        end
      end
      if (clr) begin
        m_cnt = 0; m_err = 1'b0; m_gt = 0; m_eq = 0; m_lt = 0;
      end
      if (q.size() > 0 && q[q.size()-1] != m_filt) m_state = 1;
      else if (m_filt != 3'b000)                   m_state = 2;
      else                                         m_state = 0;
    end
  end

  // Every-cycle comparison of DUT against the model
  always @(posedge clk) begin
    #1;
    chk("m_filt",  32'(filt_o),     32'(m_filt));
    chk("m_chg",   32'(chg_o),      32'(m_chg));
    chk("m_cnt",   32'(change_cnt), 32'(m_cnt));
    chk("m_err",   32'(err),        32'(m_err));
    chk("m_state", 32'(state_o),    32'(m_state));
`ifdef CMP_HIST_EN
    chk("m_gt", 32'(gt_cnt), 32'(m_gt));
    chk("m_eq", 32'(eq_cnt), 32'(m_eq));
    chk("m_lt", 32'(lt_cnt), 32'(m_lt));
`endif
  end

  task automatic cyc(input logic v, input logic [2:0] r, input logic c, input logic rs);
    in_valid = v; r_in = r; clr = c; rst = rs;
    @(posedge clk);
    #2;
    @(negedge clk);
  endtask

  task automatic rep(input int n, input logic [2:0] r);
    for (int i = 0; i < n; i++) cyc(1'b1, r, 1'b0, 1'b0);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; in_valid = 1'b1; r_in = 3'b100; clr = 1'b0;
    // Reset held with a valid legal sample present
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 3'b100, 1'b0, 1'b1);
      chk("rst_filt", 32'(filt_o), 32'h0);
      chk("rst_chg", 32'(chg_o), 32'h0);
      chk("rst_cnt", 32'(change_cnt), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_state", 32'(state_o), 32'h0);
    end

    // Acceptance after four matching samples
    rep(3, 3'b100);
    chk("acc_pre_filt", 32'(filt_o), 32'h0);
    chk("acc_pre_state", 32'(state_o), 32'h1);
    rep(1, 3'b100);
    chk("acc_filt", 32'(filt_o), 32'h4);
    chk("acc_chg", 32'(chg_o), 32'h1);
    chk("acc_cnt", 32'(change_cnt), 32'h1);
    chk("acc_state", 32'(state_o), 32'h2);
    rep(1, 3'b100);
    chk("acc_5th_chg", 32'(chg_o), 32'h0);

    // Glitch rejection
    rep(3, 3'b010);
    rep(1, 3'b100);
    chk("glitch_abandon_state", 32'(state_o), 32'h2);
    rep(3, 3'b010);
    chk("glitch_filt", 32'(filt_o), 32'h4);
    rep(1, 3'b010);
    chk("glitch_acc_filt", 32'(filt_o), 32'h2);
    chk("glitch_acc_chg", 32'(chg_o), 32'h1);
    chk("glitch_acc_cnt", 32'(change_cnt), 32'h2);

    // Valid gaps
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      cyc((i % 2) == 0, 3'b001, 1'b0, 1'b0);
      pulses += int'(chg_o);
      if (i == 5) chk("gap_pre_filt", 32'(filt_o), 32'h2);
    end
    chk("gap_filt", 32'(filt_o), 32'h1);
    chk("gap_pulses", 32'(pulses), 32'h1);
    chk("gap_cnt", 32'(change_cnt), 32'h3);

    // Fourth change wraps a 2-bit counter
    rep(4, 3'b010);
    chk("wrap_cnt", 32'(change_cnt), 32'h0);
    chk("wrap_filt", 32'(filt_o), 32'h2);
    rep(4, 3'b100);
    chk("cnt_after_wrap", 32'(change_cnt), 32'h1);

    // Illegal sample, then clear on an accepting edge
    rep(2, 3'b001);
    rep(1, 3'b011);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_filt", 32'(filt_o), 32'h4);
    chk("ill_state", 32'(state_o), 32'h2);
    rep(3, 3'b001);
    chk("ill_run_reset", 32'(filt_o), 32'h4);
    cyc(1'b1, 3'b001, 1'b1, 1'b0);
    chk("clr_cnt", 32'(change_cnt), 32'h0);
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_chg", 32'(chg_o), 32'h1);
    chk("clr_filt", 32'(filt_o), 32'h1);
    rep(1, 3'b111);
    rep(1, 3'b000);
    chk("ill000_err", 32'(err), 32'h1);

    // Reset while settling
    rep(2, 3'b010);
    chk("settle_state", 32'(state_o), 32'h1);
    cyc(1'b0, 3'b010, 1'b0, 1'b1);
    chk("mid_rst_filt", 32'(filt_o), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_state", 32'(state_o), 32'h0);
    rep(3, 3'b010);
    chk("post_rst_filt", 32'(filt_o), 32'h0);
    chk("post_rst_state", 32'(state_o), 32'h1);
    cyc(1'b0, 3'b000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
